// File: rtl/disp_scan_pkg.sv
// disp_pkg: shared constants and types for the display scanner.
package disp_pkg;
  localparam int N_DIG_DEF = 4;
  localparam logic [31:0] AN_OFF = '1;
  typedef logic [3:0] bcd_t;
  function automatic int width_of(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/disp_scan_if.sv
// disp_scan_if: digit/dot/blanking inputs and decoder/anode outputs of the scanner.
interface disp_scan_if #(parameter int N_DIG = disp_pkg::N_DIG_DEF);
  logic [4*N_DIG-1:0] digits;
  logic [N_DIG-1:0] dot_mask;
  logic blank_lz;
  disp_pkg::bcd_t digit;
  logic dot;
  logic [N_DIG-1:0] an;
  modport master(output digits, dot_mask, blank_lz, input digit, dot, an);
  modport slave(input digits, dot_mask, blank_lz, output digit, dot, an);
endinterface

// File: rtl/disp_scan_slot_timer.sv
// slot_timer: mod-DIV slot counter with digit index; pulses mark the last cycle before a new slot/frame.
module slot_timer import disp_pkg::*; #(
  parameter int DIV = 50000,
  parameter int N_DIG = N_DIG_DEF
)(
  input logic clk,
  input logic rst,
  output logic [width_of(DIV)-1:0] cnt,
  output logic [width_of(N_DIG)-1:0] idx,
  output logic slot_start,
  output logic frame_start
);
  localparam int CW = width_of(DIV);
  localparam int IW = width_of(N_DIG);
  assign slot_start = cnt == CW'(DIV - 1);
  assign frame_start = slot_start && idx == IW'(N_DIG - 1);
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_start) begin
      cnt <= '0;
      idx <= frame_start ? '0 : idx + 1'b1;
    end else
      cnt <= cnt + 1'b1;
endmodule

// File: rtl/disp_scan.sv
// disp_scan: time-multiplexed 7-segment scanner with frame snapshot, anti-ghost gap and leading-zero blanking.
module disp_scan import disp_pkg::*; #(
  parameter int N_DIG = N_DIG_DEF,
  parameter int DIV = 50000,
  parameter int GAP = 500
)(
  input logic clk,
  input logic rst,
  disp_scan_if.slave bus
);
  localparam int CW = width_of(DIV);
  localparam int IW = width_of(N_DIG);
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx, idx_n;
  logic slot_start, frame_start, live, load, on_next, lead, sh_blz, src_blz;
  logic [4*N_DIG-1:0] sh_digits, src_digits;
  logic [N_DIG-1:0] sh_dots, src_dots, blank, an_next;
  slot_timer #(.DIV(DIV), .N_DIG(N_DIG)) u_timer (
    .clk(clk), .rst(rst), .cnt(cnt), .idx(idx),
    .slot_start(slot_start), .frame_start(frame_start)
  );
  // Outputs are computed for the state after the coming edge; on a snapshot
  // edge the live inputs stand in for the shadow being loaded on that edge.
  always_comb begin
    load = frame_start || !live;
    src_digits = load ? bus.digits : sh_digits;
    src_dots = load ? bus.dot_mask : sh_dots;
    src_blz = load ? bus.blank_lz : sh_blz;
    idx_n = slot_start ? (frame_start ? '0 : idx + 1'b1) : idx;
    on_next = slot_start ? GAP == 0 : int'(cnt) + 1 >= GAP;
    blank = '0;
    lead = src_blz;
    for (int k = N_DIG - 1; k >= 1; k--) begin
      lead = lead && src_digits[4*k +: 4] == 4'd0 && !src_dots[k];
      blank[k] = lead;
    end
    an_next = AN_OFF[N_DIG-1:0];
    if (on_next && !blank[idx_n]) an_next[idx_n] = 1'b0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      live <= 1'b0;
      sh_digits <= '0;
      sh_dots <= '0;
      sh_blz <= 1'b0;
      bus.an <= AN_OFF[N_DIG-1:0];
      bus.digit <= '0;
      bus.dot <= 1'b0;
    end else begin
      live <= 1'b1;
      if (load) begin
        sh_digits <= bus.digits;
        sh_dots <= bus.dot_mask;
        sh_blz <= bus.blank_lz;
      end
      bus.an <= an_next;
      bus.digit <= src_digits[4*idx_n +: 4];
      bus.dot <= src_dots[idx_n];
    end
endmodule

// File: tb/tb_disp_scan.sv
// tb_disp_scan: directed checks of scan order, gap, blanking, snapshot, reset abort and GAP=0.
module tb_disp_scan;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  disp_scan_if #(.N_DIG(4)) bus ();
  disp_scan_if #(.N_DIG(4)) bus0 ();
  disp_scan #(.N_DIG(4), .DIV(8), .GAP(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  disp_scan #(.N_DIG(4), .DIV(8), .GAP(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  always #5 clk = ~clk;

  task automatic test_reset_and_scan();
    logic [15:0] val = 16'h1234;
    logic [3:0] ea, ed;
    logic eo;
    bus.digits = val; bus.dot_mask = 4'b0100; bus.blank_lz = 1'b0;
    bus0.digits = val; bus0.dot_mask = 4'b0000; bus0.blank_lz = 1'b0;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.an !== 4'hF || bus.digit !== 4'd0 || bus.dot !== 1'b0) begin
      errors++;
      $display("FAIL reset: an=%b digit=%0h dot=%b, want an=1111 digit=0 dot=0", bus.an, bus.digit, bus.dot);
    end
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 8; c++) begin
        if (s != 0 || c != 0) @(negedge clk);
        ea = (c < 2) ? 4'hF : ~(4'b0001 << s);
        ed = 4'(val >> (4 * s));
        eo = (s == 2);
        checks++;
        if (bus.an !== ea) begin
          errors++;
          $display("FAIL scan_an s%0d c%0d: an=%b want %b", s, c, bus.an, ea);
        end
        if (s != 0 || c != 0) begin
          checks++;
          if (bus.digit !== ed || bus.dot !== eo) begin
            errors++;
            $display("FAIL scan_digit s%0d c%0d: digit=%0h dot=%b want %0h %b", s, c, bus.digit, bus.dot, ed, eo);
          end
        end
      end
  endtask

  task automatic test_blank(input logic [3:0] dots, input logic [3:0] blanked, input string name);
    logic [15:0] val = 16'h0050;
    logic [3:0] ea, ed;
    logic eo;
    bus.digits = val; bus.dot_mask = dots; bus.blank_lz = 1'b1;
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        ea = (c < 2 || blanked[s]) ? 4'hF : ~(4'b0001 << s);
        ed = 4'(val >> (4 * s));
        eo = dots[s];
        checks++;
        if (bus.an !== ea || bus.digit !== ed || bus.dot !== eo) begin
          errors++;
          $display("FAIL %s s%0d c%0d: an=%b digit=%0h dot=%b want %b %0h %b", name, s, c, bus.an, bus.digit, bus.dot, ea, ed, eo);
        end
      end
  endtask

  task automatic test_snapshot();
    logic [3:0] ea, ed;
    bus.digits = 16'h1234; bus.dot_mask = 4'b0000; bus.blank_lz = 1'b0;
    for (int f = 0; f < 2; f++)
      for (int s = 0; s < 4; s++)
        for (int c = 0; c < 8; c++) begin
          @(negedge clk);
          ea = (c < 2) ? 4'hF : ~(4'b0001 << s);
          ed = 4'((f == 0 ? 16'h1234 : 16'h5678) >> (4 * s));
          checks++;
          if (bus.an !== ea || bus.digit !== ed) begin
            errors++;
            $display("FAIL snapshot f%0d s%0d c%0d: an=%b digit=%0h want %b %0h", f, s, c, bus.an, bus.digit, ea, ed);
          end
          if (f == 0 && s == 2 && c == 3) bus.digits = 16'h5678;
        end
  endtask

  task automatic test_mid_reset();
    logic [3:0] ea, ed;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.an !== 4'hF || bus.digit !== 4'd0 || bus.dot !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: an=%b digit=%0h dot=%b, want 1111 0 0", bus.an, bus.digit, bus.dot);
    end
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 8; c++) begin
        if (s != 0 || c != 0) @(negedge clk);
        ea = (c < 2) ? 4'hF : ~(4'b0001 << s);
        ed = 4'(16'h5678 >> (4 * s));
        checks++;
        if (bus.an !== ea) begin
          errors++;
          $display("FAIL restart_an s%0d c%0d: an=%b want %b", s, c, bus.an, ea);
        end
        if (s != 0 || c != 0) begin
          checks++;
          if (bus.digit !== ed) begin
            errors++;
            $display("FAIL restart_digit s%0d c%0d: digit=%0h want %0h", s, c, bus.digit, ed);
          end
        end
      end
  endtask

  task automatic test_gap0();
    logic [3:0] ed;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ed = 4'hF;
      for (int k = 0; k < 4; k++)
        if (bus0.an[k] === 1'b0) ed = 4'(16'h1234 >> (4 * k));
      checks++;
      if ($countones(bus0.an) != 3 || bus0.digit !== ed) begin
        errors++;
        $display("FAIL gap0 cycle %0d: an=%b digit=%0h want one low bit and digit %0h", i, bus0.an, bus0.digit, ed);
      end
    end
  endtask

  initial begin
    test_reset_and_scan();
    test_blank(4'b0000, 4'b1100, "blank_lz");
    test_blank(4'b0100, 4'b1000, "blank_dot");
    test_snapshot();
    test_mid_reset();
    test_gap0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
endmodule
